// File: rtl/psr_cond_unit_pkg.sv
// rtl/psr_cond_unit_pkg.sv - PSR bit positions, condition codes and flag bundle shared by the PSR/branch unit.
package psr_cond_unit_pkg;

  localparam int PSR_C_BIT = 0;
  localparam int PSR_L_BIT = 2;
  localparam int PSR_F_BIT = 5;
  localparam int PSR_Z_BIT = 6;
  localparam int PSR_N_BIT = 7;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_HI = 4'h4,
    COND_LS = 4'h5,
    COND_GT = 4'h6,
    COND_LE = 4'h7,
    COND_FS = 4'h8,
    COND_FC = 4'h9,
    COND_LO = 4'hA,
    COND_HS = 4'hB,
    COND_LT = 4'hC,
    COND_GE = 4'hD,
    COND_UC = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Field order matches the flag_we bit order {C,L,F,Z,N}.
  typedef struct packed {
    logic c;
    logic l;
    logic f;
    logic z;
    logic n;
  } flags_t;

  function automatic logic [7:0] flags_to_psr8(input flags_t fl);
    logic [7:0] p;
    p            = '0;
    p[PSR_C_BIT] = fl.c;
    p[PSR_L_BIT] = fl.l;
    p[PSR_F_BIT] = fl.f;
    p[PSR_Z_BIT] = fl.z;
    p[PSR_N_BIT] = fl.n;
    return p;
  endfunction

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// rtl/psr_cond_unit_cond_eval.sv - combinational branch-condition resolver over the five PSR flags.
module cond_eval
  import psr_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_CS: taken = flags.c;
      COND_CC: taken = !flags.c;
      COND_HI: taken = flags.l;
      COND_LS: taken = !flags.l;
      COND_GT: taken = flags.n;
      COND_LE: taken = !flags.n;
      COND_FS: taken = flags.f;
      COND_FC: taken = !flags.f;
      COND_LO: taken = !flags.l && !flags.z;
      COND_HS: taken = flags.l || flags.z;
      COND_LT: taken = !flags.n && !flags.z;
      COND_GE: taken = flags.n || flags.z;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// rtl/psr_cond_unit.sv - processor status register with masked ALU flag capture, LPR load and registered branch resolve.
module psr_cond_unit
  import psr_cond_unit_pkg::*;
#(
  parameter int PSR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_c,
  input  logic             alu_f,
  input  logic             alu_l,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [4:0]       flag_we,
  input  logic             lpr_en,
  input  logic [PSR_W-1:0] lpr_data,
  output logic [PSR_W-1:0] psr,
  output logic             carry_out,
  input  logic             br_valid,
  input  logic [3:0]       br_cond,
  output logic             br_ready,
  output logic             br_done,
  output logic             br_taken
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESOLVE = 1'b1
  } state_e;

  flags_t flags_q, flags_d;
  state_e state_q, state_d;
  logic   taken_q, taken_d;
  logic   eval_taken;
  logic   unused_lpr;

  assign unused_lpr = ^{lpr_data[PSR_W-1:8], lpr_data[4:3], lpr_data[1]};

  always_comb begin
    flags_d = flags_q;
    if (lpr_en) begin
      flags_d.c = lpr_data[PSR_C_BIT];
      flags_d.l = lpr_data[PSR_L_BIT];
      flags_d.f = lpr_data[PSR_F_BIT];
      flags_d.z = lpr_data[PSR_Z_BIT];
      flags_d.n = lpr_data[PSR_N_BIT];
    end else begin
      if (flag_we[4]) flags_d.c = alu_c;
      if (flag_we[3]) flags_d.l = alu_l;
      if (flag_we[2]) flags_d.f = alu_f;
      if (flag_we[1]) flags_d.z = alu_z;
      if (flag_we[0]) flags_d.n = alu_n;
    end
  end

  // Evaluated on next-state flags so a same-cycle flag write or LPR is seen.
  cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (flags_d),
    .taken (eval_taken)
  );

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          state_d = ST_RESOLVE;
          taken_d = eval_taken;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      state_q <= ST_IDLE;
      taken_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    psr      = '0;
    psr[7:0] = flags_to_psr8(flags_q);
  end

  assign carry_out = flags_q.c;
  assign br_ready  = (state_q == ST_IDLE);
  assign br_done   = (state_q == ST_RESOLVE);
  assign br_taken  = taken_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// tb/tb_psr_cond_unit.sv - scoreboard bench for psr_cond_unit: PSR writes, LPR, forwarding, handshake and condition sweep.
module tb_psr_cond_unit;

  localparam int PSR_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_c, alu_f, alu_l, alu_n, alu_z;
  logic [4:0]       flag_we;
  logic             lpr_en;
  logic [PSR_W-1:0] lpr_data;
  logic [PSR_W-1:0] psr;
  logic             carry_out;
  logic             br_valid;
  logic [3:0]       br_cond;
  logic             br_ready, br_done, br_taken;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];
  logic [15:0] psr_m;
  logic m_busy;
  logic m_taken;

  psr_cond_unit #(.PSR_W(PSR_W)) dut (
    .clk(clk), .reset(reset),
    .alu_c(alu_c), .alu_f(alu_f), .alu_l(alu_l), .alu_n(alu_n), .alu_z(alu_z),
    .flag_we(flag_we), .lpr_en(lpr_en), .lpr_data(lpr_data),
    .psr(psr), .carry_out(carry_out),
    .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(br_ready), .br_done(br_done), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [3:0] cond, input logic [15:0] p);
    logic c, l, f, z, n;
    c = p[0]; l = p[2]; f = p[5]; z = p[6]; n = p[7];
    case (cond)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return c;
      4'h3: return ~c;
      4'h4: return l;
      4'h5: return ~l;
      4'h6: return n;
      4'h7: return ~n;
      4'h8: return f;
      4'h9: return ~f;
      4'hA: return ~l & ~z;
      4'hB: return l | z;
      4'hC: return ~n & ~z;
      4'hD: return n | z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_psr(input logic [15:0] p);
    logic [15:0] r;
    r = p;
    if (lpr_en) begin
      r = lpr_data & 16'h00E5;
    end else begin
      if (flag_we[4]) r[0] = alu_c;
      if (flag_we[3]) r[2] = alu_l;
      if (flag_we[2]) r[5] = alu_f;
      if (flag_we[1]) r[6] = alu_z;
      if (flag_we[0]) r[7] = alu_n;
    end
    return r;
  endfunction

  task automatic set_flags(input logic [4:0] we, input logic [4:0] fv);
    flag_we = we;
    {alu_c, alu_l, alu_f, alu_z, alu_n} = fv;
  endtask

  task automatic idle_inputs();
    set_flags(5'h00, 5'h00);
    lpr_en   = 1'b0;
    lpr_data = '0;
    br_valid = 1'b0;
    br_cond  = 4'h0;
  endtask

  // Advances the reference model with the currently driven inputs, then clocks.
  task automatic cycle();
    logic [15:0] nxt;
    nxt = ref_psr(psr_m);
    if (!m_busy && br_valid) begin
      m_taken = ref_taken(br_cond, nxt);
      exp_q.push_back(m_taken);
      m_busy = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
    psr_m = nxt;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (br_done) begin
      if (exp_q.size() == 0) check_eq("spurious_done", br_done, 32'd0);
      else                   check_eq("br_taken", br_taken, exp_q.pop_front());
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b0;
    psr_m   = '0;
    m_busy  = 1'b0;
    m_taken = 1'b0;

    check_eq("reset_psr", psr, 32'h0000);
    check_eq("reset_carry", carry_out, 32'd0);
    check_eq("reset_ready", br_ready, 32'd1);
    check_eq("reset_done", br_done, 32'd0);
    check_eq("reset_taken", br_taken, 32'd0);

    set_flags(5'b11111, 5'b11111);
    cycle();
    check_eq("we_all_psr", psr, 32'h00E5);
    check_eq("we_all_carry", carry_out, 32'd1);

    set_flags(5'b00010, 5'b00000);
    cycle();
    check_eq("we_z_only_psr", psr, 32'h00A5);

    set_flags(5'b11111, 5'b00000);
    lpr_en = 1'b1; lpr_data = 16'hFFFF;
    cycle();
    check_eq("lpr_wins_psr", psr, 32'h00E5);
    lpr_en = 1'b0; lpr_data = '0;

    set_flags(5'b00010, 5'b00000);
    cycle();
    check_eq("z_cleared_psr", psr, {16'd0, psr_m});

    // Same-cycle Z write must be seen by EQ.
    set_flags(5'b00010, 5'b00010);
    br_valid = 1'b1; br_cond = 4'h0;
    cycle();
    check_eq("fwd_done", br_done, 32'd1);
    check_eq("fwd_ready", br_ready, 32'd0);
    check_eq("fwd_psr", psr, {16'd0, psr_m});
    set_flags(5'b00000, 5'b00000);
    br_cond = 4'hF;
    cycle();
    check_eq("held_ignored_done", br_done, 32'd0);
    check_eq("held_ready", br_ready, 32'd1);
    check_eq("held_taken", br_taken, {31'd0, m_taken});
    cycle();
    check_eq("second_done", br_done, 32'd1);
    br_valid = 1'b0;
    cycle();
    check_eq("second_taken_held", br_taken, {31'd0, m_taken});

    for (int cnd = 0; cnd < 16; cnd++) begin
      for (int fv = 0; fv < 32; fv++) begin
        set_flags(5'b11111, fv[4:0]);
        br_valid = 1'b1;
        br_cond  = cnd[3:0];
        cycle();
        check_eq("sweep_done", br_done, 32'd1);
        check_eq("sweep_psr", psr, {16'd0, psr_m});
        idle_inputs();
        cycle();
        check_eq("sweep_ready", br_ready, 32'd1);
        check_eq("sweep_held", br_taken, {31'd0, m_taken});
      end
    end

    br_valid = 1'b1; br_cond = 4'hE;
    cycle();
    check_eq("abort_pre_done", br_done, 32'd1);
    br_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    psr_m = '0; m_busy = 1'b0; m_taken = 1'b0;
    check_eq("abort_done", br_done, 32'd0);
    check_eq("abort_taken", br_taken, 32'd0);
    check_eq("abort_ready", br_ready, 32'd1);
    check_eq("abort_psr", psr, 32'h0000);
    cycle();
    check_eq("abort_no_done", br_done, 32'd0);

    @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
